prgrm_seq_unit: RTL and testbench

//  Parametrised program sequencer that replaces the fixed 8-bit PC path. Holds the 4-state control FSM,

---
 rtl/prgrm_seq_unit_pkg.sv | 22 ++
 rtl/prgrm_ret_stk.sv | 50 +++++
 rtl/prgrm_seq_unit.sv | 145 ++++++++++++++
 tb/tb_prgrm_seq_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prgrm_seq_unit_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding, flow-control opcodes
// and the opcode field width (the opcode occupies the top OPC_W bits of the instruction).
package prgrm_seq_unit_pkg;

   localparam int STATE_W = 2;
   localparam int OPC_W   = 4;

   typedef enum logic [STATE_W-1:0] {
      FETCH   = 2'd0,
      DECODE  = 2'd1,
      EXECUTE = 2'd2,
      UPDATE  = 2'd3
   } state_type;

   localparam logic [OPC_W-1:0] OP_JMP  = 4'd1;
   localparam logic [OPC_W-1:0] OP_JZ   = 4'd2;
   localparam logic [OPC_W-1:0] OP_JC   = 4'd3;
   localparam logic [OPC_W-1:0] OP_JN   = 4'd4;
   localparam logic [OPC_W-1:0] OP_CALL = 4'd5;
   localparam logic [OPC_W-1:0] OP_RET  = 4'd6;

endpackage

// File: rtl/prgrm_ret_stk.sv
// Circular hardware return-address stack. A push while full overwrites the oldest entry,
// because the write pointer has wrapped onto it; pop while empty is ignored.
module prgrm_ret_stk
   import prgrm_seq_unit_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [AW-1:0]                push_data,
   output logic [AW-1:0]                pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int DW = $clog2(DEPTH+1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

   logic [AW-1:0] mem [DEPTH];
   logic [PW-1:0] top;
   logic [PW-1:0] below;

   assign below    = (top == '0) ? LAST : top - 1'b1;
   assign pop_data = mem[below];
   assign full     = (depth == DW'(DEPTH));
   assign empty    = (depth == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         top   <= '0;
         depth <= '0;
      end else if (push) begin
         top <= (top == LAST) ? '0 : top + 1'b1;
         if (!full) depth <= depth + 1'b1;
      end else if (pop && !empty) begin
         top   <= below;
         depth <= depth - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[top] <= push_data;
   end

endmodule

// File: rtl/prgrm_seq_unit.sv
// Program sequencer top: 4-state control FSM, flow-control decode, branch evaluation and
// next-PC mux. Define PRGRM_SEQ_STK_TRAP_EN to trap on stack overflow/underflow.
//
//  state   | meaning
//  FETCH   | instruction address (pc) presented to memory
//  DECODE  | opcode and immediate captured
//  EXECUTE | ALU flags captured
//  UPDATE  | pc and return stack written on the exit edge
module prgrm_seq_unit
   import prgrm_seq_unit_pkg::*;
#(
   parameter int            AW       = 8,
   parameter int            IW       = 32,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] TRAP_VEC = 'hF0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [IW-1:0]                crnt_instrn,
   input  logic                         zro_flag,
   input  logic                         carry_flag,
   input  logic                         neg_flag,
   output logic [1:0]                   current_state,
   output logic [AW-1:0]                pc,
   output logic [$clog2(DEPTH+1)-1:0]   stk_depth,
   output logic                         stk_full,
   output logic                         stk_empty,
   output logic                         trap
);

   state_type        state, state_nxt;
   logic [OPC_W-1:0] opc_q;
   logic [AW-1:0]    imm_q;
   logic             zro_q, carry_q, neg_q;
   logic [AW-1:0]    pc_inc, pc_nxt, pop_data;
   logic             upd_go, push, pop, fault;
   logic             unused_instr;

   // Middle instruction bits belong to the ALU, not to this block.
   assign unused_instr = ^crnt_instrn;
   assign upd_go       = (state == UPDATE) && !stall;

`ifdef PRGRM_SEQ_STK_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
   logic trap_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) trap_q <= 1'b0;
      else        trap_q <= upd_go && fault;
   end
   assign trap = trap_q;
`else
   localparam bit TRAP_EN = 1'b0;
   assign trap = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!stall) begin
         case (state)
            FETCH:   state_nxt = DECODE;
            DECODE:  state_nxt = EXECUTE;
            EXECUTE: state_nxt = UPDATE;
            default: state_nxt = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         opc_q   <= '0;
         imm_q   <= '0;
         zro_q   <= 1'b0;
         carry_q <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         if ((state == DECODE) && !stall) begin
            opc_q <= crnt_instrn[IW-1 -: OPC_W];
            imm_q <= crnt_instrn[AW-1:0];
         end
         if ((state == EXECUTE) && !stall) begin
            zro_q   <= zro_flag;
            carry_q <= carry_flag;
            neg_q   <= neg_flag;
         end
      end
   end

   always_comb begin
      pc_inc = pc + 1'b1;
      pc_nxt = pc_inc;
      push   = 1'b0;
      pop    = 1'b0;
      fault  = 1'b0;
      case (opc_q)
         OP_JMP: pc_nxt = imm_q;
         OP_JZ:  if (zro_q)   pc_nxt = imm_q;
         OP_JC:  if (carry_q) pc_nxt = imm_q;
         OP_JN:  if (neg_q)   pc_nxt = imm_q;
         OP_CALL: begin
            if (TRAP_EN && stk_full) fault = 1'b1;
            else begin
               push   = upd_go;
               pc_nxt = imm_q;
            end
         end
         OP_RET: begin
            // Without the trap, an empty RET falls through as a plain increment.
            if (stk_empty) fault = TRAP_EN;
            else begin
               pop    = upd_go;
               pc_nxt = pop_data;
            end
         end
         default: ;
      endcase
      if (fault) pc_nxt = TRAP_VEC;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      pc <= '0;
      else if (upd_go) pc <= pc_nxt;
   end

   prgrm_ret_stk #(.AW(AW), .DEPTH(DEPTH)) u_ret_stk (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .pop_data  (pop_data),
      .depth     (stk_depth),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   assign current_state = state;

endmodule

// File: tb/tb_prgrm_seq_unit.sv
// Self-checking bench for prgrm_seq_unit: directed scenarios plus a randomized run, all checked
// against a queue-based model of the sequencer's architectural behaviour.
module tb_prgrm_seq_unit;

   localparam int AW    = 8;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int TVEC  = 'hF0;
`ifdef PRGRM_SEQ_STK_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          stall = 1'b0;
   logic [IW-1:0] crnt_instrn = '0;
   logic          zro_flag = 1'b0, carry_flag = 1'b0, neg_flag = 1'b0;
   logic [1:0]    current_state;
   logic [AW-1:0] pc;
   logic [2:0]    stk_depth;
   logic          stk_full, stk_empty, trap;

   int checks = 0;
   int errors = 0;

   // reference model: architectural pc and a bounded return-address queue
   int mpc = 0;
   int stk[$];
   bit exp_trap = 1'b0;

   always #5 clk = ~clk;

   prgrm_seq_unit #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .TRAP_VEC(8'hF0)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .crnt_instrn   (crnt_instrn),
      .zro_flag      (zro_flag),
      .carry_flag    (carry_flag),
      .neg_flag      (neg_flag),
      .current_state (current_state),
      .pc            (pc),
      .stk_depth     (stk_depth),
      .stk_full      (stk_full),
      .stk_empty     (stk_empty),
      .trap          (trap)
   );

   task automatic model_step(input int op, input int imm, input bit z, input bit c, input bit n);
      int inc;
      inc = (mpc + 1) % 256;
      exp_trap = 1'b0;
      case (op)
         1: mpc = imm;
         2: mpc = z ? imm : inc;
         3: mpc = c ? imm : inc;
         4: mpc = n ? imm : inc;
         5: begin
            if (TRAP_EN && stk.size() == DEPTH) begin
               mpc = TVEC;
               exp_trap = 1'b1;
            end else begin
               stk.push_back(inc);
               if (stk.size() > DEPTH) void'(stk.pop_front());
               mpc = imm;
            end
         end
         6: begin
            if (stk.size() == 0) begin
               if (TRAP_EN) begin
                  mpc = TVEC;
                  exp_trap = 1'b1;
               end else mpc = inc;
            end else mpc = stk.pop_back();
         end
         default: mpc = inc;
      endcase
   endtask

   // Runs one instruction starting at a negedge in FETCH; checks hold-until-UPDATE and the result.
   task automatic exec(input int op, input int imm, input bit z, input bit c, input bit n,
                       input int stall_at, input int stall_len, input bit toggle);
      logic [19:0]   mid;
      logic [AW-1:0] old_pc;
      logic [2:0]    old_depth;
      mid = 20'($urandom);
      crnt_instrn = {4'(op), mid, 8'(imm)};
      zro_flag = z; carry_flag = c; neg_flag = n;
      old_pc = 8'(mpc);
      old_depth = 3'(stk.size());
      model_step(op, imm, z, c, n);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (current_state !== 2'(k) || pc !== old_pc || stk_depth !== old_depth) begin
            errors++;
            $display("FAIL exec_hold op=%0d k=%0d: state=%0d pc=%h depth=%0d, expected state=%0d pc=%h depth=%0d",
                     op, k, current_state, pc, stk_depth, k, old_pc, old_depth);
         end
         if (k == 3 && toggle) begin
            zro_flag = !z; carry_flag = !c; neg_flag = !n;
         end
         if (k == stall_at) begin
            stall = 1'b1;
            repeat (stall_len) begin
               @(posedge clk); @(negedge clk);
               checks++;
               if (current_state !== 2'(k) || pc !== old_pc || stk_depth !== old_depth) begin
                  errors++;
                  $display("FAIL stall_hold op=%0d k=%0d: state=%0d pc=%h depth=%0d, expected state=%0d pc=%h depth=%0d",
                           op, k, current_state, pc, stk_depth, k, old_pc, old_depth);
               end
            end
            stall = 1'b0;
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (current_state !== 2'd0 || pc !== 8'(mpc) || stk_depth !== 3'(stk.size()) ||
          stk_full !== (stk.size() == DEPTH) || stk_empty !== (stk.size() == 0) || trap !== exp_trap) begin
         errors++;
         $display("FAIL exec_result op=%0d imm=%h: state=%0d pc=%h depth=%0d full=%b empty=%b trap=%b, expected state=0 pc=%h depth=%0d full=%b empty=%b trap=%b",
                  op, imm, current_state, pc, stk_depth, stk_full, stk_empty, trap,
                  8'(mpc), stk.size(), stk.size() == DEPTH, stk.size() == 0, exp_trap);
      end
   endtask

   task automatic run(input int op, input int imm);
      exec(op, imm, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      stall = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++;
      if (current_state !== 2'd0 || pc !== 8'h00 || stk_depth !== 3'd0 || stk_empty !== 1'b1 ||
          stk_full !== 1'b0 || trap !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: state=%0d pc=%h depth=%0d empty=%b full=%b trap=%b, expected 0 00 0 1 0 0",
                  current_state, pc, stk_depth, stk_empty, stk_full, trap);
      end
      reset = 1'b1;
      mpc = 0;
      stk.delete();
   endtask

   task automatic test_nop();
      for (int i = 0; i < 3; i++) run(0, $urandom_range(0, 255));
      checks++;
      if (pc !== 8'h03) begin
         errors++;
         $display("FAIL nop_seq: pc=%h, expected 03", pc);
      end
   endtask

   task automatic test_branch();
      exec(2, 'h40, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
      exec(2, 'h80, 1'b0, 1'b1, 1'b1, -1, 0, 1'b1);
      exec(2, 'h90, 1'b1, 1'b0, 1'b0, -1, 0, 1'b1);
      exec(3, 'h22, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0);
      exec(3, 'h33, 1'b0, 1'b1, 1'b0, -1, 0, 1'b1);
      exec(4, 'h44, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
      exec(4, 'h55, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
      run(1, 'hA7);
   endtask

   task automatic test_call_ret();
      run(1, 'h10);
      run(5, 'h80);
      run(6, 'h00);
      checks++;
      if (pc !== 8'h11 || stk_empty !== 1'b1) begin
         errors++;
         $display("FAIL call_ret: pc=%h empty=%b, expected 11 1", pc, stk_empty);
      end
   endtask

   task automatic test_overflow();
      test_reset();
      for (int i = 0; i < 5; i++) run(5, 'h20 + 'h10 * i);
      for (int i = 0; i < 5; i++) run(6, 'h00);
   endtask

   task automatic test_wrap();
      run(1, 'hFF);
      run(0, 'h12);
      run(1, 'hFF);
      run(5, 'h33);
      run(6, 'h00);
   endtask

   task automatic test_stall();
      exec(0, 'h00, 1'b0, 1'b0, 1'b0, 2, 3, 1'b0);
      exec(5, 'h66, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0);
      exec(2, 'h77, 1'b1, 1'b0, 1'b0, 1, 2, 1'b0);
      // abort an instruction in UPDATE with an asynchronous reset
      crnt_instrn = {4'd1, 20'd0, 8'h99};
      repeat (3) begin @(posedge clk); @(negedge clk); end
      reset = 1'b0;
      #1;
      checks++;
      if (current_state !== 2'd0 || pc !== 8'h00 || stk_depth !== 3'd0) begin
         errors++;
         $display("FAIL async_reset: state=%0d pc=%h depth=%0d, expected 0 00 0", current_state, pc, stk_depth);
      end
      @(negedge clk);
      reset = 1'b1;
      mpc = 0;
      stk.delete();
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         int op, sat;
         op  = $urandom_range(0, 8);
         sat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         exec(op, $urandom_range(0, 255), 1'($urandom), 1'($urandom), 1'($urandom),
              sat, $urandom_range(1, 3), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_branch();
      test_call_ret();
      test_overflow();
      test_wrap();
      test_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
